// File: rtl/fifo_1clk_ext_if.sv
// fifo_1clk_ext_if: write/read handshake and status bundle for fifo_1clk_ext.
interface fifo_1clk_ext_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic [WIDTH-1:0]         din;
    logic                     wr_en;
    logic                     full;
    logic                     almost_full;
    logic                     rd_en;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic                     empty;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;
    modport master (
        output din, wr_en, rd_en,
        input  full, almost_full, dout, dout_valid, empty, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  din, wr_en, rd_en,
        output full, almost_full, dout, dout_valid, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_1clk_ext.sv
// fifo_1clk_ext: single-clock FIFO with standard/FWFT read, occupancy count,
// threshold flags and registered overflow/underflow pulses.
module fifo_1clk_ext #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input logic            clk,
    input logic            rst_n,
    fifo_1clk_ext_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = AF_THRESH[AW:0];
    localparam logic [AW:0] AE = AE_THRESH[AW:0];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, cnt;
    logic [WIDTH-1:0] dout_r;
    logic             valid_r, ovf, udf, full, empty, wr_acc, rd_acc;
    // Wrap bit distinguishes full from empty when the address bits match.
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty  = wr_ptr == rd_ptr;
    assign cnt    = wr_ptr - rd_ptr;
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (rd_acc) dout_r <= mem[rd_ptr[AW-1:0]];
            valid_r <= rd_acc;
            ovf     <= bus.wr_en && full;
            udf     <= bus.rd_en && empty;
        end
    end
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = cnt;
    assign bus.almost_full  = cnt >= AF;
    assign bus.almost_empty = cnt <= AE;
    assign bus.overflow     = ovf;
    assign bus.underflow    = udf;
    // FWFT presents the head word directly; standard mode shows the registered read.
    assign bus.dout         = (FWFT != 0) ? mem[rd_ptr[AW-1:0]] : dout_r;
    assign bus.dout_valid   = (FWFT != 0) ? !empty : valid_r;
endmodule
